// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller: default sizing
// and the controller state encoding.
package serial_subtractor_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_ctrl_full_subtractor.sv
// One-bit combinational full subtractor cell: difference = x - y - b,
// borrow set when the subtraction needs to borrow from the next bit.
module full_subtractor (
    output logic borrow,
    output logic difference,
    input  logic x,
    input  logic y,
    input  logic b
);

    assign difference = x ^ y ^ b;
    assign borrow     = (~x & (y | b)) | (y & b);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b: one full_subtractor cell stepped LSB first over WIDTH cycles,
// borrow carried in a flop, result held until the next operation completes.
//
// state  | meaning
// S_IDLE | waiting for start; operands latched on accept
// S_RUN  | one bit per cycle through the cell, LSB first
// S_DONE | result valid, done pulse for one cycle
module serial_subtractor_ctrl
    import serial_subtractor_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] r_diff;
    logic [CNT_W-1:0] r_cnt;
    logic             r_borrow;
    logic             r_borrow_out;
    logic             w_cell_borrow;
    logic             w_cell_diff;
    logic             w_last;

    full_subtractor u_cell (
        .borrow     (w_cell_borrow),
        .difference (w_cell_diff),
        .x          (r_a_sh[0]),
        .y          (r_b_sh[0]),
        .b          (r_borrow)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Result fills from the MSB end; written as shift/or so WIDTH=1 needs no special case.
    assign w_res_next = (r_res_sh >> 1) | (WIDTH'(w_cell_diff) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_res_sh     <= '0;
            r_cnt        <= '0;
            r_borrow     <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_res_sh <= '0;
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_res_sh <= w_res_next;
                    r_borrow <= w_cell_borrow;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_diff       <= w_res_next;
                        r_borrow_out <= w_cell_borrow;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: directed vector table, start/reset
// corner sequences, randomized operations against an arithmetic model, and a WIDTH=1 instance.
module tb_serial_subtractor_ctrl;
    import serial_subtractor_ctrl_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    logic       clk;
    logic       rst8, start8, busy8, done8, bo8;
    logic [7:0] a8, b8, diff8;
    logic       rst1, start1, busy1, done1, bo1;
    logic [0:0] a1, b1, diff1;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] prev_d;
    logic       prev_bo;
    vec_t       vecs[7];

    serial_subtractor_ctrl #(.WIDTH(8), .CNT_W(5)) dut8 (
        .clk(clk), .reset(rst8), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    serial_subtractor_ctrl #(.WIDTH(1), .CNT_W(5)) dut1 (
        .clk(clk), .reset(rst1), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_diff8(input int av, input int bv);
        return 8'((av + 256 - bv) % 256);
    endfunction

    // One operation on the 8-bit instance; noise scribbles on start/a/b while busy.
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv,
                           input logic [7:0] ed, input logic eb, input bit noise);
        int lat;
        a8 = av; b8 = bv; start8 = 1'b1;
        tick();
        start8 = noise ? 1'($urandom) : 1'b0;
        if (noise) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
        end
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            check("busy_run", busy8, 1);
            check("diff_hold", diff8, prev_d);
            check("bo_hold", bo8, prev_bo);
            tick();
            lat++;
            if (noise) begin
                start8 = 1'($urandom);
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
        end
        check("latency", lat, W);
        check("diff", diff8, ed);
        check("borrow_out", bo8, eb);
        check("busy_done", busy8, 1);
        start8 = 1'b0;
        tick();
        check("done_fall", done8, 0);
        check("busy_fall", busy8, 0);
        check("diff_after", diff8, ed);
        prev_d  = ed;
        prev_bo = eb;
    endtask

    task automatic run_op1(input logic [0:0] av, input logic [0:0] bv);
        int lat;
        logic ed, eb;
        ed = 1'((int'(av) + 2 - int'(bv)) % 2);
        eb = (av < bv);
        a1 = av; b1 = bv; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        lat = 0;
        while (done1 !== 1'b1 && lat < 10) begin
            check("w1_busy_run", busy1, 1);
            tick();
            lat++;
        end
        check("w1_latency", lat, 1);
        check("w1_diff", diff1, ed);
        check("w1_borrow", bo1, eb);
        tick();
        check("w1_done_fall", done1, 0);
        check("w1_busy_fall", busy1, 0);
    endtask

    initial begin
        bit   exp_busy, exp_done;
        logic [7:0] ra, rb;

        vecs[0] = '{a: 8'd200, b: 8'd55,  d: 8'd145, bo: 1'b0};
        vecs[1] = '{a: 8'd5,   b: 8'd10,  d: 8'd251, bo: 1'b1};
        vecs[2] = '{a: 8'd0,   b: 8'd1,   d: 8'd255, bo: 1'b1};
        vecs[3] = '{a: 8'd255, b: 8'd255, d: 8'd0,   bo: 1'b0};
        vecs[4] = '{a: 8'd0,   b: 8'd0,   d: 8'd0,   bo: 1'b0};
        vecs[5] = '{a: 8'd128, b: 8'd1,   d: 8'd127, bo: 1'b0};
        vecs[6] = '{a: 8'd1,   b: 8'd255, d: 8'd2,   bo: 1'b1};

        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
        rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0;
        tick();
        tick();
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_diff", diff8, 0);
        check("rst_bo", bo8, 0);
        check("w1_rst_busy", busy1, 0);
        check("w1_rst_diff", diff1, 0);
        rst8 = 1'b0; rst1 = 1'b0;
        prev_d = 8'd0; prev_bo = 1'b0;
        tick();
        check("idle_busy", busy8, 0);

        foreach (vecs[i]) begin
            run_op8(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, 1'b0);
        end

        // start held high; operands changed mid-run must not matter
        a8 = 8'd100; b8 = 8'd1; start8 = 1'b1;
        tick();
        a8 = 8'd7; b8 = 8'd9;
        for (int c = 1; c <= 18; c++) begin
            tick();
            exp_busy = (c <= 8) || (c >= 10);
            exp_done = (c == 8) || (c == 18);
            check("held_busy", busy8, exp_busy);
            check("held_done", done8, exp_done);
            if (c == 8) begin
                check("held_diff1", diff8, 99);
                check("held_bo1", bo8, 0);
            end
            if (c == 18) begin
                check("held_diff2", diff8, 254);
                check("held_bo2", bo8, 1);
            end
        end
        start8 = 1'b0;
        tick();
        prev_d = 8'd254; prev_bo = 1'b1;

        // reset on the 4th RUN edge aborts without a done pulse
        run_op8(8'd200, 8'd55, 8'd145, 1'b0, 1'b0);
        a8 = 8'd10; b8 = 8'd3; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("abort_busy", busy8, 1);
            check("abort_hold", diff8, 145);
        end
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        check("abort_busy0", busy8, 0);
        check("abort_done0", done8, 0);
        check("abort_diff0", diff8, 0);
        check("abort_bo0", bo8, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("abort_no_done", done8, 0);
        end
        prev_d = 8'd0; prev_bo = 1'b0;
        run_op8(8'd10, 8'd3, 8'd7, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom);
            rb = (n % 8 == 0) ? ra : 8'($urandom);
            run_op8(ra, rb, model_diff8(int'(ra), int'(rb)), (ra < rb), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                tick();
                check("gap_idle", busy8, 0);
            end
        end

        for (int i = 0; i < 4; i++) begin
            run_op1(1'(i >> 1), 1'(i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
